// File: rtl/bus_cycle_sequencer_if.sv
// Bus bundle between the 6809 side (CPU pins plus peripheral ports) and the bus-cycle sequencer.
// The master modport drives the CPU and peripheral inputs; the sequencer uses the slave modport.
interface bus_cycle_sequencer_if #(
    parameter int NUM_REGIONS = 4,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int WAIT_W      = 4
);
    logic                          e_clk;
    logic                          rw;
    logic [ADDR_W-1:0]             address;
    logic [NUM_REGIONS*ADDR_W-1:0] region_base;
    logic [NUM_REGIONS*ADDR_W-1:0] region_mask;
    logic [NUM_REGIONS*WAIT_W-1:0] region_wait;
    logic [NUM_REGIONS-1:0]        region_stretch;
    logic [NUM_REGIONS-1:0]        region_ready;
    logic [NUM_REGIONS*DATA_W-1:0] region_rdata;

    logic [NUM_REGIONS-1:0]        region_sel;
    logic                          rd_strobe;
    logic                          wr_strobe;
    logic [DATA_W-1:0]             data_out;
    logic                          data_oe;
    logic                          dben;
    logic                          mrdy;
    logic                          timeout;

    modport master (
        output e_clk, rw, address, region_base, region_mask, region_wait,
               region_stretch, region_ready, region_rdata,
        input  region_sel, rd_strobe, wr_strobe, data_out, data_oe, dben, mrdy, timeout
    );

    modport slave (
        input  e_clk, rw, address, region_base, region_mask, region_wait,
               region_stretch, region_ready, region_rdata,
        output region_sel, rd_strobe, wr_strobe, data_out, data_oe, dben, mrdy, timeout
    );
endinterface

// File: rtl/bus_cycle_sequencer.sv
// 6809 bus-cycle engine: syncs E, decodes NUM_REGIONS address regions and sequences each access.
// Optional ready watchdog is enabled by defining BUS_TIMEOUT_EN.
module bus_cycle_sequencer #(
    parameter int NUM_REGIONS    = 4,
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 8,
    parameter int WAIT_W         = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    bus_cycle_sequencer_if.slave bus
);

    localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

    state_t             state;
    state_t             state_next;
    logic [SYNC_STAGES-1:0] e_sync;
    logic               e_prev;
    logic               e_rise;
    logic               e_fall;
    logic               hit;
    logic [IDX_W-1:0]   hit_idx;
    logic [WAIT_W-1:0]  hit_wait;
    logic [IDX_W-1:0]   sel_idx;
    logic               rw_q;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [DATA_W-1:0]  data_q;
    logic               oe_q;
    logic               ready_sel;
    logic               stretch_sel;
    logic               tmo_hit;
    logic               latch;
    logic               complete;
    logic               drop_oe;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            e_sync <= '0;
            e_prev <= 1'b0;
        end else begin
            e_sync <= {e_sync[SYNC_STAGES-2:0], bus.e_clk};
            e_prev <= e_sync[SYNC_STAGES-1];
        end
    end

    assign e_rise = e_sync[SYNC_STAGES-1] & ~e_prev;
    assign e_fall = ~e_sync[SYNC_STAGES-1] & e_prev;

    // Descending scan so the lowest matching region index wins on overlap.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int k = NUM_REGIONS - 1; k >= 0; k--) begin
            if ((bus.address & bus.region_mask[k*ADDR_W +: ADDR_W]) ==
                (bus.region_base[k*ADDR_W +: ADDR_W] & bus.region_mask[k*ADDR_W +: ADDR_W])) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(k);
            end
        end
    end

    assign hit_wait    = bus.region_wait[hit_idx*WAIT_W +: WAIT_W];
    assign ready_sel   = bus.region_ready[sel_idx];
    assign stretch_sel = bus.region_stretch[sel_idx];

`ifdef BUS_TIMEOUT_EN
    localparam int TMO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [TMO_W-1:0] tmo_cnt;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            tmo_cnt <= '0;
        end else if (state == ACCESS && !ready_sel) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end else begin
            tmo_cnt <= '0;
        end
    end

    assign tmo_hit = (state == ACCESS) && !ready_sel && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    // Without the watchdog TIMEOUT_CYCLES has no effect and ACCESS waits on ready forever.
    assign tmo_hit = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        state_next     = state;
        latch          = 1'b0;
        complete       = 1'b0;
        drop_oe        = 1'b0;
        bus.region_sel = '0;
        bus.rd_strobe  = 1'b0;
        bus.wr_strobe  = 1'b0;
        bus.dben       = 1'b1;
        bus.mrdy       = 1'b1;
        bus.timeout    = 1'b0;
        if (state != IDLE) begin
            bus.region_sel[sel_idx] = 1'b1;
            bus.dben                = 1'b0;
        end
        case (state)
            IDLE: begin
                if (e_rise && hit) begin
                    latch      = 1'b1;
                    state_next = SETUP;
                end
            end
            SETUP: begin
                bus.mrdy = ~stretch_sel;
                if (e_fall) begin
                    state_next = IDLE;
                end else if (wait_cnt == '0) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                bus.rd_strobe = rw_q;
                bus.wr_strobe = ~rw_q;
                if (e_fall) begin
                    state_next = IDLE;
                end else if (ready_sel || tmo_hit) begin
                    complete    = 1'b1;
                    bus.timeout = ~ready_sel;
                    state_next  = HOLD;
                end else begin
                    bus.mrdy = ~stretch_sel;
                end
            end
            HOLD: begin
                if (e_fall) begin
                    drop_oe    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Wait counts load one short so a count of N gives N SETUP cycles; zero still gets one.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state    <= IDLE;
            sel_idx  <= '0;
            rw_q     <= 1'b0;
            wait_cnt <= '0;
            data_q   <= '0;
            oe_q     <= 1'b0;
        end else begin
            state <= state_next;
            if (latch) begin
                sel_idx  <= hit_idx;
                rw_q     <= bus.rw;
                wait_cnt <= (hit_wait == '0) ? '0 : hit_wait - WAIT_W'(1);
            end else if (state == SETUP && wait_cnt != '0) begin
                wait_cnt <= wait_cnt - WAIT_W'(1);
            end
            if (complete && rw_q) begin
                data_q <= ready_sel ? bus.region_rdata[sel_idx*DATA_W +: DATA_W] : '1;
                oe_q   <= 1'b1;
            end else if (drop_oe) begin
                oe_q <= 1'b0;
            end
        end
    end

    assign bus.data_out = data_q;
    assign bus.data_oe  = oe_q;

endmodule
